register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits (8..64).
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two (4..64); AW = clog2(NREGS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port n_rs1_rd  input  1  active-low read enable, port 1.
REQ-006 SHALL have port n_rs2_rd  input  1  active-low read enable, port 2.
REQ-007 SHALL have port n_rd_wr  input  1  active-low write enable.
REQ-008 SHALL have ports rs1a, rs2a, rda  input  AW  read-1, read-2 and write addresses.
REQ-009 SHALL have port rd  input  XLEN  write data.
REQ-010 SHALL have ports rs1, rs2  output  XLEN  registered read data.
REQ-011 SHALL have ports rs1_valid, rs2_valid  output  1  rsN holds data from a read issued in the previous cycle.
REQ-012 SHALL have port ready  output  1  bank initialised and accepting reads/writes.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-014 CLEAR: one register per cycle, index 1 up to NREGS-1, written with 0; ready=0; port requests ignored.
REQ-015 CLEAR -> RUN on the cycle after index NREGS-1 is written; CLEAR therefore lasts exactly NREGS-1 cycles after reset release.
REQ-016 RUN is terminal until rst; ready=1 throughout RUN.
REQ-017 Register 0 SHALL read as 0 always; writes with rda=0 SHALL be discarded; register 0 need not be stored.
REQ-018 Write in RUN: when n_rd_wr=0 at an edge, reg[rda] <= rd.
REQ-019 Read in RUN: when n_rsN_rd=0 at edge k, rsN <= reg[rsNa] and rsN_valid <= 1 at k; 1-cycle latency.
REQ-020 When n_rsN_rd=1 at an edge, rsN SHALL hold its previous value and rsN_valid <= 0.
REQ-021 Bypass: a read and a write at the same edge with rsNa == rda != 0 SHALL return the new rd, not the stale value.
REQ-022 Same-edge bypass with rda=0 SHALL still return 0.
REQ-023 Both ports MAY read the same address in the same cycle; both SHALL return identical data.
REQ-024 Reads and writes in CLEAR SHALL leave rs1, rs2 at 0 and rsN_valid at 0.
REQ-025 Out-of-range addresses cannot occur (NREGS power of two); no wrap handling is needed.

Reset
REQ-026 rst=1 SHALL asynchronously force: state=CLEAR, clear index=1, rs1=rs2=0, rs1_valid=rs2_valid=0, ready=0.
REQ-027 Storage array SHALL NOT be reset directly; CLEAR sweep zeroes it.
REQ-028 rst asserted mid-CLEAR or mid-RUN SHALL restart the full sweep from index 1 on release; in-flight writes are lost.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (CLEAR, RUN) and default XLEN/NREGS constants.
REQ-030 Storage SHALL be one sub-module, regfile_2r1w (NREGS x XLEN, 2 async read ports, 1 sync write port); register_bank holds the FSM, bypass, zero forcing and output registers.

Verification
REQ-031 Reset release with NREGS=32 -> ready=0 for exactly 31 cycles, then 1; all 31 registers read 0.
REQ-032 Write rda=5, rd=0xF0E0D0C0; next cycle read rs1a=5 -> rs1=0xF0E0D0C0, rs1_valid=1 one cycle later.
REQ-033 Write rda=0, rd=0xFFFFFFFF, same-edge read rs2a=0 -> rs2=0; later read of 0 -> 0.
REQ-034 Same edge: write rda=15, rd=0x12345678, read rs1a=rs2a=15 -> rs1=rs2=0x12345678 next cycle.
REQ-035 Read rs1a=5, then n_rs1_rd=1 -> rs1 holds 0xF0E0D0C0, rs1_valid=0.
REQ-036 rst pulse during RUN after writes -> ready=0 for 31 cycles, register 5 reads 0 afterwards; repeat with XLEN=16, NREGS=8 -> 7-cycle CLEAR.

Source files
------------

// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: FSM state encoding and default geometry.
package register_bank_pkg;
   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;
endpackage

// File: rtl/register_bank_regfile_2r1w.sv
// NREGS x XLEN storage with two combinational read ports and one synchronous write port.
module regfile_2r1w
   import register_bank_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);
   // No reset: contents are established by the owner's clear sweep.
   logic [XLEN-1:0] mem [NREGS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1 = mem[raddr1];
   assign rdata2 = mem[raddr2];
endmodule

// File: rtl/register_bank.sv
// Two-read/one-write register bank that zeroes itself after reset, with write-to-read
// bypass, hard-wired zero register and registered read outputs.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            n_rs1_rd,
   input  logic            n_rs2_rd,
   input  logic            n_rd_wr,
   input  logic [AW-1:0]   rs1a,
   input  logic [AW-1:0]   rs2a,
   input  logic [AW-1:0]   rda,
   input  logic [XLEN-1:0] rd,
   output logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] rs2,
   output logic            rs1_valid,
   output logic            rs2_valid,
   output logic            ready
);
   state_t          state_reg, state_next;
   logic [AW-1:0]   clr_idx_reg, clr_idx_next;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            run;
   logic [1:0]      rd_en;
   logic [AW-1:0]   rd_addr  [2];
   logic [XLEN-1:0] rf_rdata [2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= CLEAR;
         clr_idx_reg <= AW'(1);
      end else begin
         state_reg   <= state_next;
         clr_idx_reg <= clr_idx_next;
      end
   end

   // CLEAR owns the write port; register 0 is never stored, so the sweep starts at 1.
   always_comb begin
      state_next   = state_reg;
      clr_idx_next = clr_idx_reg;
      wr_en        = 1'b0;
      wr_addr      = rda;
      wr_data      = rd;
      case (state_reg)
         CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = clr_idx_reg;
            wr_data = '0;
            if (clr_idx_reg == AW'(NREGS - 1)) begin
               state_next = RUN;
            end else begin
               clr_idx_next = clr_idx_reg + AW'(1);
            end
         end
         RUN: begin
            wr_en = ~n_rd_wr && (rda != '0);
         end
         default: state_next = CLEAR;
      endcase
   end

   assign run        = (state_reg == RUN);
   assign ready      = run;
   assign rd_en      = {~n_rs2_rd, ~n_rs1_rd} & {2{run}};
   assign rd_addr[0] = rs1a;
   assign rd_addr[1] = rs2a;

   regfile_2r1w #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_regfile (
      .clk    (clk),
      .we     (wr_en),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .raddr1 (rs1a),
      .raddr2 (rs2a),
      .rdata1 (rf_rdata[0]),
      .rdata2 (rf_rdata[1])
   );

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [XLEN-1:0] data_reg, data_next;
      logic            valid_reg;

      // Zero register wins over bypass; bypass only fires for real RUN writes.
      always_comb begin
         data_next = rf_rdata[gi];
         if (rd_addr[gi] == '0) begin
            data_next = '0;
         end else if (wr_en && run && (rda == rd_addr[gi])) begin
            data_next = rd;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
         end else begin
            valid_reg <= rd_en[gi];
            if (rd_en[gi]) begin
               data_reg <= data_next;
            end
         end
      end
   end

   assign rs1       = g_port[0].data_reg;
   assign rs2       = g_port[1].data_reg;
   assign rs1_valid = g_port[0].valid_reg;
   assign rs2_valid = g_port[1].valid_reg;
endmodule

// File: tb/tb_register_bank.sv
// Directed, table-driven check of register_bank in the default 32x32 geometry and a 16x8 one.
module tb_register_bank;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default geometry DUT
   logic        rst, n_rs1_rd, n_rs2_rd, n_rd_wr;
   logic [4:0]  rs1a, rs2a, rda;
   logic [31:0] rd, rs1, rs2;
   logic        rs1_valid, rs2_valid, ready;

   // Small geometry DUT
   logic        s_rst, s_n1, s_n2, s_nw;
   logic [2:0]  s_rs1a, s_rs2a, s_rda;
   logic [15:0] s_rd, s_rs1, s_rs2;
   logic        s_v1, s_v2, s_ready;

   register_bank dut (
      .clk(clk), .rst(rst), .n_rs1_rd(n_rs1_rd), .n_rs2_rd(n_rs2_rd), .n_rd_wr(n_rd_wr),
      .rs1a(rs1a), .rs2a(rs2a), .rda(rda), .rd(rd), .rs1(rs1), .rs2(rs2),
      .rs1_valid(rs1_valid), .rs2_valid(rs2_valid), .ready(ready)
   );

   register_bank #(.XLEN(16), .NREGS(8)) dut_small (
      .clk(clk), .rst(s_rst), .n_rs1_rd(s_n1), .n_rs2_rd(s_n2), .n_rd_wr(s_nw),
      .rs1a(s_rs1a), .rs2a(s_rs2a), .rda(s_rda), .rd(s_rd), .rs1(s_rs1), .rs2(s_rs2),
      .rs1_valid(s_v1), .rs2_valid(s_v2), .ready(s_ready)
   );

   typedef struct {
      logic        n1, n2, nw;
      logic [4:0]  a1, a2, ad;
      logic [31:0] d, e1, e2;
      logic        v1, v2;
   } vec_t;

   vec_t vecs [11];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_main();
      n_rs1_rd = 1'b1; n_rs2_rd = 1'b1; n_rd_wr = 1'b1;
      rs1a = '0; rs2a = '0; rda = '0; rd = '0;
   endtask

   task automatic idle_small();
      s_n1 = 1'b1; s_n2 = 1'b1; s_nw = 1'b1;
      s_rs1a = '0; s_rs2a = '0; s_rda = '0; s_rd = '0;
   endtask

   // Junk writes/reads are driven throughout CLEAR; they must be ignored.
   task automatic wait_ready_main(output int n);
      n = 0;
      n_rd_wr = 1'b0; rda = 5'd9; rd = 32'h5555_5555;
      n_rs1_rd = 1'b0; rs1a = 5'd9; n_rs2_rd = 1'b0; rs2a = 5'd0;
      while (n < 100) begin
         step();
         n++;
         if (ready) break;
         chk("clear_rs1", {rs1_valid, rs1}, 33'h0);
         chk("clear_rs2", {rs2_valid, rs2}, 33'h0);
      end
      idle_main();
   endtask

   task automatic wait_ready_small(output int n);
      n = 0;
      while (n < 100) begin
         step();
         n++;
         if (s_ready) break;
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd5,  32'hF0E0D0C0, 32'h0,        32'h0,        1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 5'd5,  5'd0,  5'd0,  32'h0,        32'hF0E0D0C0, 32'h0,        1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 5'd7,  5'd0,  5'd0,  32'h0,        32'hF0E0D0C0, 32'h0,        1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hF0E0D0C0, 32'h0,        1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        1'b1, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd15, 5'd15, 5'd15, 32'h12345678, 32'h12345678, 32'h12345678, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd15, 5'd5,  5'd0,  32'h0,        32'h12345678, 32'hF0E0D0C0, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'd5,  5'd3,  5'd5,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        1'b1, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd5,  5'd31, 5'd0,  32'h0,        32'hA5A5A5A5, 32'h0,        1'b1, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd31, 32'hDEADBEEF, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 5'd0,  5'd31, 5'd0,  32'h0,        32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b1};

      rst = 1'b1; s_rst = 1'b1;
      idle_main();
      idle_small();
      #12;
      chk("reset_ready", ready, 1'b0);
      chk("reset_rs", {rs1_valid, rs2_valid, rs1, rs2}, 66'h0);
      chk("reset_small", {s_ready, s_v1, s_v2, s_rs1, s_rs2}, 35'h0);

      // Release between edges; ready must rise after exactly 31 edges.
      step();
      rst = 1'b0;
      wait_ready_main(cyc);
      chk("clear_len", cyc, 31);
      $display("clear sweep finished after %0d cycles", cyc);

      for (int i = 0; i < 32; i++) begin
         n_rs1_rd = 1'b0; n_rs2_rd = 1'b0;
         rs1a = 5'(i); rs2a = 5'(31 - i);
         step();
         chk("sweep_rs1", {rs1_valid, rs1}, {1'b1, 32'h0});
         chk("sweep_rs2", {rs2_valid, rs2}, {1'b1, 32'h0});
      end
      idle_main();
      step();

      for (int i = 0; i < 11; i++) begin
         n_rs1_rd = vecs[i].n1; n_rs2_rd = vecs[i].n2; n_rd_wr = vecs[i].nw;
         rs1a = vecs[i].a1; rs2a = vecs[i].a2; rda = vecs[i].ad; rd = vecs[i].d;
         step();
         $display("vec %0d: rs1=%h/%b rs2=%h/%b", i, rs1, rs1_valid, rs2, rs2_valid);
         chk("vec_rs1", rs1, vecs[i].e1);
         chk("vec_rs2", rs2, vecs[i].e2);
         chk("vec_v1", rs1_valid, vecs[i].v1);
         chk("vec_v2", rs2_valid, vecs[i].v2);
      end
      idle_main();

      // Asynchronous reset in RUN: outputs clear before any clock edge.
      #2 rst = 1'b1;
      #1;
      chk("async_rst", {ready, rs1_valid, rs1}, 34'h0);
      step();
      rst = 1'b0;
      wait_ready_main(cyc);
      chk("reclear_len", cyc, 31);
      n_rs1_rd = 1'b0; rs1a = 5'd5; n_rs2_rd = 1'b0; rs2a = 5'd15;
      step();
      chk("reclear_r5", {rs1_valid, rs1}, {1'b1, 32'h0});
      chk("reclear_r15", {rs2_valid, rs2}, {1'b1, 32'h0});
      idle_main();

      // Small geometry: reset mid-CLEAR restarts the sweep.
      s_rst = 1'b0;
      step(); step(); step();
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      wait_ready_small(cyc);
      chk("small_clear_len", cyc, 7);
      s_nw = 1'b0; s_rda = 3'd5; s_rd = 16'hBEEF;
      step();
      s_nw = 1'b1; s_n1 = 1'b0; s_rs1a = 3'd5; s_n2 = 1'b0; s_rs2a = 3'd0;
      step();
      $display("small read: rs1=%h rs2=%h", s_rs1, s_rs2);
      chk("small_rs1", {s_v1, s_rs1}, {1'b1, 16'hBEEF});
      chk("small_rs2", {s_v2, s_rs2}, {1'b1, 16'h0});
      idle_small();
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      wait_ready_small(cyc);
      chk("small_reclear_len", cyc, 7);
      s_n1 = 1'b0; s_rs1a = 3'd5;
      step();
      chk("small_reclear_r5", {s_v1, s_rs1}, {1'b1, 16'h0});
      idle_small();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
